// File: rtl/data_sync_pkg.sv
// Shared defaults for the clock-domain-crossing blocks (reset synchronizer
// and data_sync instances pick up the same stage count and bus width).
package data_sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int BUS_WIDTH_DEF   = 8;
  localparam int CNT_WIDTH_DEF   = 8;

endpackage

// File: rtl/data_sync_pulse_gen.sv
// Rising-edge detector: turns a level into a registered one-cycle strobe.
module pulse_gen (
  input  logic CLK,
  input  logic RST,
  input  logic LVL_SIG,
  output logic PULSE_SIG
);

  logic lvl_q;
  logic pulse_d;
  logic pulse_q;

  // A rise is the level high now while the delayed copy is still low.
  always_comb begin
    pulse_d = LVL_SIG & ~lvl_q;
  end

  // Delay register for the level and the registered strobe, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lvl_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      lvl_q   <= LVL_SIG;
      pulse_q <= pulse_d;
    end
  end

  assign PULSE_SIG = pulse_q;

endmodule

// File: rtl/data_sync.sv
// Destination-domain bus synchronizer: a source-held enable is passed
// through a flop chain, edge-detected, and the rise captures the bus.
module data_sync
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = SYNC_STAGES_DEF,
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic [CNT_WIDTH-1:0] CAPTURE_CNT
);

  logic [NUM_STAGES-1:0] syncChain_q;
  logic                  syncEn;
  logic                  enDly_q;
  logic                  rise;
  logic [BUS_WIDTH-1:0]  syncBus_q;
  logic [BUS_WIDTH-1:0]  syncBus_d;
  logic [CNT_WIDTH-1:0]  capCnt_q;
  logic [CNT_WIDTH-1:0]  capCnt_d;

  // Multi-flop synchronizer on the foreign enable; bit 0 is the first sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      syncChain_q <= '0;
    end else begin
      syncChain_q <= {syncChain_q[NUM_STAGES-2:0], BUS_ENABLE};
    end
  end

  assign syncEn = syncChain_q[NUM_STAGES-1];

  // The capture must happen on the same edge the strobe goes high, so it is
  // qualified by the combinational rise; pulse_gen only exposes the registered
  // strobe, hence this local copy of the delayed level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      enDly_q <= 1'b0;
    end else begin
      enDly_q <= syncEn;
    end
  end

  assign rise = syncEn & ~enDly_q;

  // Next-state for the captured bus and the wrapping capture counter.
  always_comb begin
    syncBus_d = syncBus_q;
    capCnt_d  = capCnt_q;
    if (rise) begin
      syncBus_d = UNSYNC_BUS;
      capCnt_d  = capCnt_q + CNT_WIDTH'(1);
    end
  end

  // Output data and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      syncBus_q <= '0;
      capCnt_q  <= '0;
    end else begin
      syncBus_q <= syncBus_d;
      capCnt_q  <= capCnt_d;
    end
  end

  pulse_gen uPulseGen (
    .CLK       (CLK),
    .RST       (RST),
    .LVL_SIG   (syncEn),
    .PULSE_SIG (ENABLE_PULSE)
  );

  assign SYNC_BUS    = syncBus_q;
  assign CAPTURE_CNT = capCnt_q;

endmodule

// File: tb/tb_data_sync.sv
// Directed bench for data_sync: default instance plus a 2-bit counter
// instance and a 4-stage instance, all driven from the same stimulus.
module tb_data_sync;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BUS_ENABLE;
  logic [7:0] UNSYNC_BUS;

  logic [7:0] dutBus;
  logic       dutPulse;
  logic [7:0] dutCnt;
  logic [7:0] wrapBus;
  logic       wrapPulse;
  logic [1:0] wrapCnt;
  logic [7:0] deepBus;
  logic       deepPulse;
  logic [7:0] deepCnt;

  int errors = 0;
  int checks = 0;

  data_sync dut (
    .CLK          (CLK),
    .RST          (RST),
    .UNSYNC_BUS   (UNSYNC_BUS),
    .BUS_ENABLE   (BUS_ENABLE),
    .SYNC_BUS     (dutBus),
    .ENABLE_PULSE (dutPulse),
    .CAPTURE_CNT  (dutCnt)
  );

  data_sync #(.CNT_WIDTH(2)) dutWrap (
    .CLK          (CLK),
    .RST          (RST),
    .UNSYNC_BUS   (UNSYNC_BUS),
    .BUS_ENABLE   (BUS_ENABLE),
    .SYNC_BUS     (wrapBus),
    .ENABLE_PULSE (wrapPulse),
    .CAPTURE_CNT  (wrapCnt)
  );

  data_sync #(.NUM_STAGES(4)) dutDeep (
    .CLK          (CLK),
    .RST          (RST),
    .UNSYNC_BUS   (UNSYNC_BUS),
    .BUS_ENABLE   (BUS_ENABLE),
    .SYNC_BUS     (deepBus),
    .ENABLE_PULSE (deepPulse),
    .CAPTURE_CNT  (deepCnt)
  );

  // Free-running destination clock.
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] bus);
    RST        = rst;
    BUS_ENABLE = en;
    UNSYNC_BUS = bus;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One full handshake: enable high 8 cycles, then low for lowCycles.
  task automatic runTransfer(input logic [7:0] data, input logic [7:0] prevBus,
                             input logic [7:0] expCnt, input logic [1:0] expWrap,
                             input int lowCycles);
    applyStimulus(1'b0, 1'b1, data);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput("pulse", 32'(dutPulse), 32'(i == 3));
      checkOutput("deepPulse", 32'(deepPulse), 32'(i == 5));
      checkOutput("bus", 32'(dutBus), 32'((i >= 3) ? data : prevBus));
      if (i == 6) UNSYNC_BUS = 8'h11;
    end
    checkOutput("cnt", 32'(dutCnt), 32'(expCnt));
    checkOutput("wrapCnt", 32'(wrapCnt), 32'(expWrap));
    checkOutput("deepBus", 32'(deepBus), 32'(data));
    checkOutput("deepCnt", 32'(deepCnt), 32'(expCnt));
    applyStimulus(1'b0, 1'b0, UNSYNC_BUS);
    for (int i = 1; i <= lowCycles; i++) begin
      tick();
      checkOutput("lowPulse", 32'(dutPulse), 32'(0));
      checkOutput("lowDeepPulse", 32'(deepPulse), 32'(0));
      checkOutput("lowBus", 32'(dutBus), 32'(data));
    end
  endtask

  logic [7:0] wrapData [4];
  logic [1:0] wrapExp  [4];

  // Directed sequence: reset, transfers, mid-flight reset, counter wrap.
  initial begin
    wrapData = '{8'h21, 8'h42, 8'h84, 8'h18};
    wrapExp  = '{2'd2, 2'd3, 2'd0, 2'd1};

    applyStimulus(1'b1, 1'b1, 8'hFF);
    for (int i = 1; i <= 2; i++) begin
      tick();
      checkOutput("rstBus", 32'(dutBus), 32'(0));
      checkOutput("rstPulse", 32'(dutPulse), 32'(0));
      checkOutput("rstCnt", 32'(dutCnt), 32'(0));
      checkOutput("rstWrapCnt", 32'(wrapCnt), 32'(0));
      checkOutput("rstDeepPulse", 32'(deepPulse), 32'(0));
    end

    applyStimulus(1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput("idlePulse", 32'(dutPulse), 32'(0));
    end

    runTransfer(8'hA5, 8'h00, 8'd1, 2'd1, 8);
    runTransfer(8'h3C, 8'hA5, 8'd2, 2'd2, 5);
    runTransfer(8'hC3, 8'h3C, 8'd3, 2'd3, 8);

    applyStimulus(1'b0, 1'b1, 8'h5A);
    tick();
    checkOutput("midPrePulse", 32'(dutPulse), 32'(0));
    checkOutput("midPreBus", 32'(dutBus), 32'(8'hC3));
    applyStimulus(1'b1, 1'b1, 8'h5A);
    tick();
    checkOutput("midRstPulse", 32'(dutPulse), 32'(0));
    checkOutput("midRstBus", 32'(dutBus), 32'(0));
    checkOutput("midRstCnt", 32'(dutCnt), 32'(0));
    checkOutput("midRstWrap", 32'(wrapCnt), 32'(0));
    applyStimulus(1'b0, 1'b1, 8'h5A);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput("midPulse", 32'(dutPulse), 32'(i == 3));
      checkOutput("midDeepPulse", 32'(deepPulse), 32'(i == 5));
      checkOutput("midBus", 32'(dutBus), 32'((i >= 3) ? 8'h5A : 8'h00));
    end
    checkOutput("midCnt", 32'(dutCnt), 32'(1));
    checkOutput("midWrap", 32'(wrapCnt), 32'(1));
    applyStimulus(1'b0, 1'b0, 8'h5A);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput("midLowPulse", 32'(dutPulse), 32'(0));
    end

    for (int k = 0; k < 4; k++) begin
      runTransfer(wrapData[k], (k == 0) ? 8'h5A : wrapData[k-1],
                  8'(k + 2), wrapExp[k], 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
